// File: rtl/chunk_serial_adder_if.sv
// rtl/chunk_serial_adder_if.sv - operand/result handshake bundle for chunk_serial_adder
interface chunk_serial_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/chunk_serial_adder.sv
// rtl/chunk_serial_adder.sv - multi-cycle add/subtract, one CHUNK-bit slice per clock
// Operand registers shift right each BUSY cycle; the result shifts in from the top.
module chunk_serial_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    chunk_serial_adder_if.slave  bus
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_last;
    logic [CHUNK:0]   w_slice;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_sum_next;

    assign w_last  = (r_cnt == CW'(NSLICE - 1));
    assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the slice MSB, recovered from the MSB sum bit.
    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_slice[CHUNK-1];

    generate
        if (CHUNK == WIDTH) begin : g_single
            assign w_sum_next = w_slice[CHUNK-1:0];
        end else begin : g_multi
            assign w_sum_next = {w_slice[CHUNK-1:0], r_sum[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = BUSY;
            BUSY:    if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b ^ {WIDTH{bus.sub}};
                        r_carry <= bus.sub | bus.c_in;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_slice[CHUNK];
                        r_ovf  <= w_msb_cin ^ w_slice[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum   = r_sum;
    assign bus.c_out = r_cout;
    assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb/tb_chunk_serial_adder.sv - directed self-checking bench for chunk_serial_adder (WIDTH=64, CHUNK=8)
module tb_chunk_serial_adder;
    localparam int WIDTH  = 64;
    localparam int CHUNK  = 8;
    localparam int NSLICE = WIDTH / CHUNK;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    chunk_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sb, input string tag);
        int wait_cnt;
        wait_cnt = 0;
        while (bus.in_ready !== 1'b1 && wait_cnt < 50) begin
            @(posedge clk); @(negedge clk);
            wait_cnt++;
        end
        check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        bus.a = a; bus.b = b; bus.c_in = cin; bus.sub = sb; bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        bus.c_in = ~cin; bus.sub = ~sb;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sb,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf, input string tag);
        int lat;
        accept(a, b, cin, sb, tag);
        check({tag, "_busy_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(NSLICE));
        check({tag, "_sum"}, bus.sum, exp_sum);
        check({tag, "_c_out"}, {63'd0, bus.c_out}, {63'd0, exp_cout});
        check({tag, "_ovf"}, {63'd0, bus.ovf}, {63'd0, exp_ovf});
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] held_sum;
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_sum", bus.sum, 64'd0);
        check("reset_flags", {62'd0, bus.c_out, bus.ovf}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, "carry_chain");
        run_op(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        run_op(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, "add_ovf");
        run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "add_mixed");
        run_op(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 1'b0,
               64'h0100_0100_0100_0100, 1'b0, 1'b0, "alt_carry");
        run_op(64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0, "sub_ignores_cin");

        // Reset while the counter sits on slice 3.
        accept(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0, "rst_mid");
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0, "after_rst");

        // Backpressure: result held while in_valid and a toggle.
        accept(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "bp");
        repeat (NSLICE) @(negedge clk);
        check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        check("bp_sum", bus.sum, 64'h8000_0000_0000_0000);
        held_sum = bus.sum;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.a = {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
            check("bp_hold", {bus.sum[WIDTH-1:3], bus.out_valid, bus.in_ready, bus.ovf},
                  {held_sum[WIDTH-1:3], 1'b1, 1'b0, 1'b1});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        @(posedge clk); @(negedge clk);
        check("bp_no_accept", {63'd0, bus.in_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
